// File: rtl/core_define.sv
// Shared LSU definitions: memory-op direction codes, legal access lengths,
// and the bus-controller state encoding.
package core_define;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [2:0] MEM_LEN_BYTE = 3'd1;
  localparam logic [2:0] MEM_LEN_HALF = 3'd2;
  localparam logic [2:0] MEM_LEN_WORD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_WAIT1 = 3'd4
  } lsu_state_e;

  function automatic logic mem_len_legal(input logic [2:0] len);
    return (len == MEM_LEN_BYTE) || (len == MEM_LEN_HALF) || (len == MEM_LEN_WORD);
  endfunction

endpackage

// File: rtl/core_ma_lsu_lane_gen.sv
// Byte-lane steering for one bus beat: byte enables and rotated write data.
// Beat 0 carries the low bytes shifted up to the address offset; beat 1
// carries whatever spilled past the word boundary.
module core_ma_lsu_lane_gen (
  input  logic [1:0]  off,
  input  logic [2:0]  len,
  input  logic [31:0] data,
  input  logic        beat,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata
);

  logic [3:0] len_mask;
  logic [2:0] spill_sh;
  logic [5:0] sh_lo;
  logic [5:0] sh_hi;

  // Select the lane pattern for the requested beat
  always_comb begin
    // 4-bit arithmetic makes len=4 wrap to 4'hF naturally
    len_mask = (4'd1 << len) - 4'd1;
    spill_sh = 3'd4 - {1'b0, off};
    sh_lo    = {1'b0, off, 3'b000};
    sh_hi    = 6'd32 - sh_lo;
    if (beat) begin
      byte_en = len_mask >> spill_sh;
      wdata   = data >> sh_hi;
    end else begin
      byte_en = len_mask << off;
      wdata   = data << sh_lo;
    end
  end

endmodule

// File: rtl/core_ma_lsu_bus_ctrl.sv
// MA-stage load/store to Avalon-MM master bridge. Splits word-crossing
// accesses into two beats, one bus transaction outstanding at a time.
module core_ma_lsu_bus_ctrl
  import core_define::*;
(
  input  logic        clk,
  input  logic        rest,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic [2:0]  mem_op_data_len,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err,
  output logic [31:0] avl_m0_address,
  output logic        avl_m0_read,
  output logic        avl_m0_write,
  output logic [3:0]  avl_m0_byte_en,
  output logic [31:0] avl_m0_write_data,
  input  logic        avl_m0_waitrequest,
  input  logic        avl_m0_read_data_valid
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic        split_q, split_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req;
  logic        done_c;
  logic        err_c;
  logic        beat_done;
  logic        last_beat;
  logic [3:0]  span;
  logic [1:0]  lane_off;
  logic [2:0]  lane_len;
  logic [31:0] lane_data;
  logic        lane_beat;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  assign req = mem_read | mem_write;

  // In IDLE the lanes are computed from the incoming request (beat 0);
  // afterwards only beat 1 is ever loaded, from the latched request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      lane_off  = mem_addr[1:0];
      lane_len  = mem_op_data_len;
      lane_data = mem_write_data;
      lane_beat = 1'b0;
    end else begin
      lane_off  = off_q;
      lane_len  = len_q;
      lane_data = data_q;
      lane_beat = 1'b1;
    end
  end

  core_ma_lsu_lane_gen u_lane_gen (
    .off     (lane_off),
    .len     (lane_len),
    .data    (lane_data),
    .beat    (lane_beat),
    .byte_en (lane_be),
    .wdata   (lane_wdata)
  );

  // Next-state and next-bus-output computation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    off_d     = off_q;
    len_d     = len_q;
    data_d    = data_q;
    split_d   = split_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    done_c    = 1'b0;
    err_c     = 1'b0;
    beat_done = 1'b0;
    span      = {2'b00, mem_addr[1:0]} + {1'b0, mem_op_data_len};
    last_beat = (state_q == ST_BEAT1) || (state_q == ST_WAIT1) || !split_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!mem_len_legal(mem_op_data_len)) begin
            // Rejected in place: no bus traffic, stay idle
            done_c = 1'b1;
            err_c  = 1'b1;
          end else begin
            op_d    = mem_read ? MEM_OP_LOAD : MEM_OP_STORE;
            off_d   = mem_addr[1:0];
            len_d   = mem_op_data_len;
            data_d  = mem_write_data;
            split_d = (span > 4'd4);
            addr_d  = {mem_addr[31:2], 2'b00};
            rd_d    = mem_read;
            wr_d    = !mem_read;
            be_d    = lane_be;
            wdata_d = lane_wdata;
            state_d = ST_BEAT0;
          end
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (!avl_m0_waitrequest) begin
          if (op_q == MEM_OP_LOAD) begin
            rd_d    = 1'b0;
            state_d = (state_q == ST_BEAT0) ? ST_WAIT0 : ST_WAIT1;
          end else begin
            beat_done = 1'b1;
          end
        end
      end
      ST_WAIT0, ST_WAIT1: begin
        if (avl_m0_read_data_valid) beat_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat_done) begin
      if (last_beat) begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
        op_d    = MEM_OP_NONE;
        addr_d  = 32'd0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = 4'd0;
        wdata_d = 32'd0;
      end else begin
        state_d = ST_BEAT1;
        addr_d  = addr_q + 32'd4;
        rd_d    = (op_q == MEM_OP_LOAD);
        wr_d    = (op_q == MEM_OP_STORE);
        be_d    = lane_be;
        wdata_d = lane_wdata;
      end
    end
  end

  // State and registered bus outputs; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= ST_IDLE;
      op_q    <= MEM_OP_NONE;
      off_q   <= 2'd0;
      len_q   <= 3'd0;
      data_q  <= 32'd0;
      split_q <= 1'b0;
      addr_q  <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      len_q   <= len_d;
      data_q  <= data_d;
      split_q <= split_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign avl_m0_address    = addr_q;
  assign avl_m0_read       = rd_q;
  assign avl_m0_write      = wr_q;
  assign avl_m0_byte_en    = be_q;
  assign avl_m0_write_data = wdata_q;
  assign mem_done          = done_c & rest;
  assign mem_err           = err_c & rest;
  assign mem_busy          = ((state_q != ST_IDLE) || req) && !mem_done;

endmodule

// File: doc/core_ma_lsu_bus_ctrl.md
CORE_MA_LSU_BUS_CTRL -- requirements
Module: core_ma_lsu_bus_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rest  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: mem_read / mem_write  in  1 each  load/store request from MA stage, held until mem_done.
REQ-004 SHALL have ports: mem_addr  in  32  byte address.
REQ-005 SHALL have ports: mem_write_data  in  32  store data, LSB-aligned.
REQ-006 SHALL have ports: mem_op_data_len  in  3  access size in bytes (1, 2, 4 legal).
REQ-007 SHALL have ports: mem_busy  out  1  pipeline stall; mem_done  out  1  completion pulse; mem_err  out  1  illegal-length pulse.
REQ-008 SHALL have ports: avl_m0_address  out  32  word-aligned; avl_m0_read, avl_m0_write  out  1; avl_m0_byte_en  out  4; avl_m0_write_data  out  32.
REQ-009 SHALL have ports: avl_m0_waitrequest  in  1; avl_m0_read_data_valid  in  1.

Function
REQ-010 SHALL implement FSM IDLE, BEAT0, WAIT0, BEAT1, WAIT1; request is accepted only in IDLE; mem_read wins if both are asserted.
REQ-011 SHALL latch addr, data, len and direction on acceptance; bus outputs are registered and assert on the cycle after acceptance.
REQ-012 SHALL set split = ({1'b0,addr[1:0]} + len) > 4; unsplit accesses run BEAT0 only.
REQ-013 SHALL drive beat0: address {addr[31:2],2'b00}; byte_en (((1<<len)-1)<<off) & 4'hF; write_data = data<<(8*off), where off = addr[1:0].
REQ-014 SHALL drive beat1: address = beat0 + 4 (mod 2^32); byte_en ((1<<len)-1)>>(4-off); write_data = data>>(8*(4-off)).
REQ-015 SHALL hold avl_m0_address, byte_en, write_data, read and write stable while avl_m0_waitrequest=1.
REQ-016 SHALL, on a write beat, complete the beat on the cycle avl_m0_write && !waitrequest, then advance to BEAT1 or IDLE.
REQ-017 SHALL, on a read beat, drop avl_m0_read on accept (->WAITn) and complete the beat on avl_m0_read_data_valid; one transaction outstanding, beat1 is never issued before beat0 data.
REQ-018 SHALL assert mem_done combinationally for one cycle on completion of the final beat; FSM is IDLE on the next cycle.
REQ-019 SHALL drive mem_busy = (state!=IDLE || mem_read || mem_write) && !mem_done.
REQ-020 SHALL, for len not in {1,2,4}, pulse mem_err and mem_done in the acceptance cycle, issue no bus access, and keep state IDLE.
REQ-021 SHALL ignore avl_m0_read_data_valid in IDLE, BEATn, and write transactions.

Reset
REQ-022 SHALL, on rest low, immediately force state IDLE and all avl_m0_* outputs to 0, and drive mem_done and mem_err to 0, regardless of the in-flight transaction.
REQ-023 SHALL, after reset release, ignore stale read_data_valid responses; the next request starts fresh.

Structure
REQ-024 SHALL define FSM state enum and legal-length constants in core_define.sv beside the MEM_OP_* codes.
REQ-025 SHALL place lane byte-enable and write-data rotation in combinational sub-module core_ma_lsu_lane_gen (inputs off, len, data, beat; outputs byte_en, wdata).

Verification
REQ-026 SHALL cover: read 0x100 len4, no wait, valid 2 cycles later -> one beat, addr 0x100, be 4'hF, mem_done with valid.
REQ-027 SHALL cover: read 0x103 len4 -> beat0 0x100 be 4'b1000, beat1 0x104 be 4'b0111 only after beat0 valid, single mem_done.
REQ-028 SHALL cover: write 0x202 len2 data 0x0000ABCD -> single beat, be 4'b1100, wdata 0xABCD0000.
REQ-029 SHALL cover: write 0x203 len2 data 0x1234, waitrequest high 3 cycles on beat0 -> beat0 0x200/4'b1000/0x34000000 held stable 3 cycles; beat1 0x204/4'b0001/0x00000012.
REQ-030 SHALL cover: read 0xFFFFFFFE len4 -> beat1 address 0x00000000; len3 request -> mem_err and mem_done pulse, no bus activity.
REQ-031 SHALL cover: rest low during WAIT1 -> outputs 0 and IDLE at once; late read_data_valid after release produces no mem_done.
